// File: rtl/vc_buffer_onoff_ctrl.sv
// vc_buffer_onoff_ctrl: per-VC circular flit FIFOs at a router input with hysteretic on/off signalling; optional OFF-cycle stats under `ONOFF_STATS_EN.
// Latency: a pushed flit shows on flit_o/empty_o one edge after it is written; on_off_o moves on the same edge as the count.
// Backpressure: upstream obeys on_off_o; a push to a full VC is dropped and flagged on sticky overflow_o; pops of an empty VC are ignored.
module vc_buffer_onoff_ctrl #(
   parameter int   VC_NUM      = 2,
   parameter int   BUFFER_SIZE = 8,
   parameter int   FLIT_W      = 64,
   parameter int   OFF_THRESH  = 2,
   parameter int   ON_THRESH   = 4,
   localparam int  VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_flit_i,
   input  logic [VC_W-1:0]          vc_id_i,
   input  logic [FLIT_W-1:0]        flit_i,
   input  logic                     read_i,
   input  logic [VC_W-1:0]          read_vc_i,
   output logic [VC_NUM*FLIT_W-1:0] flit_o,
   output logic [VC_NUM-1:0]        empty_o,
   output logic [VC_NUM-1:0]        on_off_o,
   output logic                     overflow_o,
   output logic [VC_NUM*16-1:0]     off_cycles_o
);

   localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
   localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
   localparam logic [CNT_W-1:0] L_SIZE = CNT_W'(BUFFER_SIZE);
   localparam logic [CNT_W-1:0] L_OFF  = CNT_W'(OFF_THRESH);
   localparam logic [CNT_W-1:0] L_ON   = CNT_W'(ON_THRESH);
   localparam logic [PTR_W-1:0] L_LAST = PTR_W'(BUFFER_SIZE - 1);

   typedef enum logic {ST_OFF = 1'b0, ST_ON = 1'b1} onoff_state_t;

   logic [VC_NUM-1:0] w_ovf;
   logic              r_overflow;

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic [FLIT_W-1:0] r_mem [BUFFER_SIZE];
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [CNT_W-1:0]  r_count;
      onoff_state_t      r_state;
      logic              w_wr_sel;
      logic              w_full;
      logic              w_empty;
      logic              w_push;
      logic              w_pop;
      logic [CNT_W-1:0]  w_cnt_next;
      logic [CNT_W-1:0]  w_free_next;

      // Full is judged on the pre-pop count, so a push+pop on a full VC drops the push.
      assign w_wr_sel    = valid_flit_i && (vc_id_i == VC_W'(v));
      assign w_full      = (r_count == L_SIZE);
      assign w_empty     = (r_count == '0);
      assign w_push      = w_wr_sel && !w_full;
      assign w_pop       = read_i && (read_vc_i == VC_W'(v)) && !w_empty;
      assign w_ovf[v]    = w_wr_sel && w_full;
      assign w_cnt_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      assign w_free_next = L_SIZE - w_cnt_next;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_ON;
         end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            r_count <= w_cnt_next;
            // Hysteresis: between the two thresholds the previous state is held.
            case (r_state)
               ST_ON:   if (w_free_next <= L_OFF) r_state <= ST_OFF;
               ST_OFF:  if (w_free_next >= L_ON)  r_state <= ST_ON;
               default: r_state <= ST_ON;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wr_ptr] <= flit_i;
      end

      assign flit_o[v*FLIT_W +: FLIT_W] = r_mem[r_rd_ptr];
      assign empty_o[v]                 = w_empty;
      assign on_off_o[v]                = (r_state == ST_ON);

`ifdef ONOFF_STATS_EN
      logic [15:0] r_off_cycles;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_off_cycles <= '0;
         end else if (r_state == ST_OFF && r_off_cycles != 16'hFFFF) begin
            r_off_cycles <= r_off_cycles + 16'd1;
         end
      end

      assign off_cycles_o[v*16 +: 16] = r_off_cycles;
`else
      assign off_cycles_o[v*16 +: 16] = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_overflow <= 1'b0;
      else      r_overflow <= r_overflow | (|w_ovf);
   end

   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_vc_buffer_onoff_ctrl.sv
// Directed bench for vc_buffer_onoff_ctrl at VC_NUM=2, BUFFER_SIZE=8, OFF_THRESH=2, ON_THRESH=4.
// Stats expectations follow `ONOFF_STATS_EN.
module tb_vc_buffer_onoff_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         valid_flit_i;
   logic [0:0]   vc_id_i;
   logic [63:0]  flit_i;
   logic         read_i;
   logic [0:0]   read_vc_i;
   logic [127:0] flit_o;
   logic [1:0]   empty_o;
   logic [1:0]   on_off_o;
   logic         overflow_o;
   logic [31:0]  off_cycles_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vc_buffer_onoff_ctrl #(
      .VC_NUM(2), .BUFFER_SIZE(8), .FLIT_W(64), .OFF_THRESH(2), .ON_THRESH(4)
   ) u_dut (
      .clk(clk), .rst(rst),
      .valid_flit_i(valid_flit_i), .vc_id_i(vc_id_i), .flit_i(flit_i),
      .read_i(read_i), .read_vc_i(read_vc_i),
      .flit_o(flit_o), .empty_o(empty_o), .on_off_o(on_off_o),
      .overflow_o(overflow_o), .off_cycles_o(off_cycles_o)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock with the given push/pop request; outputs are sampled 1 ns after the edge.
   task automatic cyc(input logic push, input logic pvc, input logic [63:0] d,
                      input logic pop, input logic rvc);
      valid_flit_i = push;
      vc_id_i      = pvc;
      flit_i       = d;
      read_i       = pop;
      read_vc_i    = rvc;
      @(posedge clk);
      #1;
      valid_flit_i = 1'b0;
      read_i       = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      valid_flit_i = 1'b0;
      vc_id_i      = 1'b0;
      flit_i       = '0;
      read_i       = 1'b0;
      read_vc_i    = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_empty",    64'(empty_o),      64'h3);
      check("rst_onoff",    64'(on_off_o),     64'h3);
      check("rst_overflow", 64'(overflow_o),   64'h0);
      check("rst_offcyc",   64'(off_cycles_o), 64'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      // 1: fill VC0 to 6; OFF only once free slots reach 2
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 64'hA0 + 64'(i), 1'b0, 1'b0);
         check("t1_onoff0", 64'(on_off_o[0]), (i < 5) ? 64'h1 : 64'h0);
         check("t1_onoff1", 64'(on_off_o[1]), 64'h1);
      end
      check("t1_empty0", 64'(empty_o[0]), 64'h0);

      // 2: drain VC0 in order; ON returns at count 4
      for (int k = 0; k < 6; k++) begin
         check("t2_head0", flit_o[63:0], 64'hA0 + 64'(k));
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
         check("t2_onoff0", 64'(on_off_o[0]), (k == 0) ? 64'h0 : 64'h1);
      end
      check("t2_empty0", 64'(empty_o[0]), 64'h1);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("t2_pop_empty0", 64'(empty_o[0]), 64'h1);

      // 3: VC1 fill, overflow on 9th, push+pop while full
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
      check("t3_ovf_before", 64'(overflow_o), 64'h0);
      check("t3_onoff1_full", 64'(on_off_o[1]), 64'h0);
      cyc(1'b1, 1'b1, 64'hB8, 1'b0, 1'b0);
      check("t3_ovf_set", 64'(overflow_o), 64'h1);
      cyc(1'b1, 1'b1, 64'hC0, 1'b1, 1'b1);
      check("t3_ovf_hold", 64'(overflow_o), 64'h1);
      check("t3_head1_after_pp", flit_o[127:64], 64'hB1);
      for (int k = 1; k < 8; k++) begin
         check("t3_head1", flit_o[127:64], 64'hB0 + 64'(k));
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      end
      check("t3_empty1", 64'(empty_o[1]), 64'h1);
      check("t3_onoff1_end", 64'(on_off_o[1]), 64'h1);

      // 4: push+pop at count 3, then on an empty VC (pointers wrap here)
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 64'hD0 + 64'(i), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 64'hD3, 1'b1, 1'b0);
      check("t4_onoff0", 64'(on_off_o[0]), 64'h1);
      check("t4_head0_pp", flit_o[63:0], 64'hD1);
      for (int k = 1; k < 4; k++) begin
         check("t4_head0", flit_o[63:0], 64'hD0 + 64'(k));
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      end
      check("t4_empty0_drained", 64'(empty_o[0]), 64'h1);
      cyc(1'b1, 1'b0, 64'hE0, 1'b1, 1'b0);
      check("t4_empty0_pp", 64'(empty_o[0]), 64'h0);
      check("t4_head0_e0", flit_o[63:0], 64'hE0);

      // 5: empty pop on VC1, bring VC0 to 5 while OFF, then async reset
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      check("t5_pop_empty1", 64'(empty_o), 64'h2);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 64'hF0 + 64'(i), 1'b0, 1'b0);
      check("t5_onoff0_6", 64'(on_off_o[0]), 64'h0);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("t5_onoff0_5", 64'(on_off_o[0]), 64'h0);
      check("t5_head0", flit_o[63:0], 64'hF0);
      #3 rst = 1'b0;
      #1;
      check("t5_rst_empty",    64'(empty_o),    64'h3);
      check("t5_rst_onoff",    64'(on_off_o),   64'h3);
      check("t5_rst_overflow", 64'(overflow_o), 64'h0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_post_empty", 64'(empty_o), 64'h3);

      // 6: OFF-cycle statistics
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 64'h60 + 64'(i), 1'b0, 1'b0);
      check("t6_onoff0", 64'(on_off_o[0]), 64'h0);
      repeat (10) @(posedge clk);
      #1;
`ifdef ONOFF_STATS_EN
      check("t6_offcyc0", 64'(off_cycles_o[15:0]), 64'd10);
`else
      check("t6_offcyc0", 64'(off_cycles_o[15:0]), 64'd0);
`endif
      check("t6_offcyc1", 64'(off_cycles_o[31:16]), 64'd0);
`ifdef ONOFF_STATS_EN
      repeat (70000) @(posedge clk);
      #1;
      check("t6_offcyc0_sat", 64'(off_cycles_o[15:0]), 64'hFFFF);
      check("t6_offcyc1_sat", 64'(off_cycles_o[31:16]), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
